// File: rtl/console_uart_pkg.sv
// rtl/console_uart_pkg.sv - shared FSM states, register map and STATUS bit positions for console_uart.
// Optional macro CONSOLE_UART_PARITY_EN adds the PARITY state.
package console_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef CONSOLE_UART_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_e;

    localparam logic [31:0] TXDATA_OFFSET = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_FULL_BIT    = 1;
    localparam int STATUS_OVERRUN_BIT = 2;
    localparam int STATUS_LEVEL_LSB   = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, power-of-two depth; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/console_uart.sv
// rtl/console_uart.sv - write-only console UART: TXDATA/STATUS register window, TX FIFO, 8N1 serialiser.
// Optional macro CONSOLE_UART_PARITY_EN inserts an even-parity bit between DATA and STOP.
module console_uart
    import console_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wenable,
    output logic [31:0] data_rdata,
    output logic        tx
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    uart_state_e state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        overrun_q, overrun_d;

    logic        sel_txdata, sel_status;
    logic        push_req, overrun_evt, status_clr;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic [8:0]  level_w;
    logic        div_end, busy;
    logic        unused_inputs;

    assign sel_txdata  = (data_addr == BASE_ADDR + TXDATA_OFFSET);
    assign sel_status  = (data_addr == BASE_ADDR + STATUS_OFFSET);
    assign push_req    = sel_txdata & data_wenable[0];
    assign overrun_evt = push_req & fifo_full;
    assign status_clr  = sel_status & data_wenable[0] & data_wdata[STATUS_OVERRUN_BIT];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (data_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
        if (state_q != IDLE) begin
            div_d = div_end ? 16'd0 : div_q + 16'd1;
        end
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d  = START;
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    div_d    = 16'd0;
                end
            end
            START: begin
                if (div_end) state_d = DATA;
            end
            DATA: begin
                if (div_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef CONSOLE_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef CONSOLE_UART_PARITY_EN
            PARITY: begin
                if (div_end) state_d = STOP;
            end
`endif
            STOP: begin
                // Chain straight into the next frame to keep the line saturated.
                if (div_end) begin
                    if (!fifo_empty) begin
                        state_d  = START;
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if (status_clr)  overrun_d = 1'b0;
        if (overrun_evt) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:  tx = 1'b0;
            DATA:   tx = shreg_q[bit_q];
`ifdef CONSOLE_UART_PARITY_EN
            PARITY: tx = ^shreg_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign busy    = (state_q != IDLE) | ~fifo_empty;
    assign level_w = 9'(fifo_level);

    always_comb begin
        data_rdata = '0;
        if (sel_status) begin
            data_rdata[STATUS_BUSY_BIT]                     = busy;
            data_rdata[STATUS_FULL_BIT]                     = fifo_full;
            data_rdata[STATUS_OVERRUN_BIT]                  = overrun_q;
            data_rdata[STATUS_LEVEL_LSB +: 8]               = level_w[7:0];
        end
    end

    assign unused_inputs = ^{data_wdata[31:8], data_wenable[3:1], level_w[8]};

endmodule

// File: tb/tb_console_uart.sv
// tb/tb_console_uart.sv - directed self-checking bench for console_uart (CLK_DIV=4, FIFO_DEPTH=4).
module tb_console_uart;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_TX   = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_BAD  = BASE + 32'h8;
`ifdef CONSOLE_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wenable;
    logic [31:0] data_rdata;
    logic        tx;

    int checks   = 0;
    int failures = 0;

    console_uart #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wenable (data_wenable),
        .data_rdata   (data_rdata),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int j);
        int idx;
        idx = j / 4;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef CONSOLE_UART_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_frame(input logic [7:0] b, input int first, input int last_excl, input string tag);
        for (int j = first; j < last_excl; j++) begin
            @(negedge clk);
            chk($sformatf("%s_cyc%0d", tag, j), {31'b0, tx}, {31'b0, exp_bit(b, j)});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] we);
        data_addr    = addr;
        data_wdata   = wd;
        data_wenable = we;
        @(posedge clk);
        #1;
        data_wenable = 4'h0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] v);
        data_addr = addr;
        #1;
        v = data_rdata;
    endtask

    task automatic count_lows(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v;
    int          lows;
    logic [7:0]  burst [6];

    initial begin
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rst = 1'b1;
        data_addr = 32'h0;
        data_wdata = 32'h0;
        data_wenable = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", {31'b0, tx}, 32'h1);
        rd(A_STAT, v); chk("reset_status", v, 32'h0);
        rd(A_TX, v);   chk("reset_txdata_read", v, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single byte 0x41, then 0x07 (parity 1 when enabled)
        bus_write(A_TX, 32'h41, 4'hF);
        chk("latency_tx_still_idle", {31'b0, tx}, 32'h1);
        rd(A_STAT, v); chk("status_after_push", v, 32'h0000_0101);
        @(posedge clk);
        #1;
        check_frame(8'h41, 0, FRAME_CYCLES, "f41");
        rd(A_STAT, v); chk("status_idle_after_41", v, 32'h0);
        chk("tx_idle_after_41", {31'b0, tx}, 32'h1);
        bus_write(A_TX, 32'h07, 4'hF);
        @(posedge clk);
        #1;
        check_frame(8'h07, 0, FRAME_CYCLES, "f07");
        rd(A_STAT, v); chk("status_idle_after_07", v, 32'h0);

        // Six writes on consecutive edges into depth-4 FIFO
        data_addr    = A_TX;
        data_wenable = 4'hF;
        for (int i = 0; i < 6; i++) begin
            data_wdata = {24'h0, burst[i]};
            @(posedge clk);
            #1;
        end
        data_wenable = 4'h0;
        rd(A_STAT, v); chk("status_full_overrun", v, 32'h0000_0407);
        check_frame(burst[0], 4, FRAME_CYCLES, "burst0");
        for (int k = 1; k < 5; k++) begin
            check_frame(burst[k], 0, FRAME_CYCLES, $sformatf("burst%0d", k));
        end
        rd(A_STAT, v); chk("status_overrun_sticky", v, 32'h0000_0004);
        count_lows(FRAME_CYCLES, lows);
        chk("no_sixth_frame", lows, 32'h0);

        // Overrun clear and non-byte-0 strobe
        bus_write(A_STAT, 32'h4, 4'h1);
        rd(A_STAT, v); chk("overrun_cleared", v, 32'h0);
        bus_write(A_TX, 32'h99, 4'b0010);
        rd(A_STAT, v); chk("no_push_we_byte1", v, 32'h0);
        @(posedge clk);
        #1;
        chk("tx_idle_no_push", {31'b0, tx}, 32'h1);

        // Unmapped address
        rd(A_BAD, v); chk("unmapped_read_idle", v, 32'h0);
        bus_write(A_BAD, 32'h41, 4'hF);
        rd(A_STAT, v); chk("unmapped_write_level", v, 32'h0);
        @(posedge clk);
        #1;
        chk("tx_idle_unmapped", {31'b0, tx}, 32'h1);

        // Reset mid-frame with two bytes queued
        data_addr    = A_TX;
        data_wenable = 4'hF;
        data_wdata   = 32'h55; @(posedge clk); #1;
        data_wdata   = 32'hAA; @(posedge clk); #1;
        data_wdata   = 32'hCC; @(posedge clk); #1;
        data_wenable = 4'h0;
        rd(A_STAT, v); chk("status_two_queued", v, 32'h0000_0201);
        rd(A_BAD, v);  chk("unmapped_read_busy", v, 32'h0);
        rd(A_TX, v);   chk("txdata_read_zero", v, 32'h0);
        check_frame(8'h55, 1, 14, "f55_partial");
        rst          = 1'b1;
        data_addr    = A_TX;
        data_wdata   = 32'h77;
        data_wenable = 4'hF;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        data_wenable = 4'h0;
        chk("tx_after_reset", {31'b0, tx}, 32'h1);
        rd(A_STAT, v); chk("status_after_reset", v, 32'h0);
        count_lows(3 * FRAME_CYCLES, lows);
        chk("no_frames_after_reset", lows, 32'h0);
        rd(A_STAT, v); chk("status_final", v, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/console_uart.md
CONSOLE_UART -- requirements
Module: console_uart

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000; base address of the two-word register window.
REQ-002 SHALL have parameter CLK_DIV, default 16; clock cycles per UART bit, legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8; TX FIFO entries, power of two, 2..256.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port data_addr  input  32  CPU data-bus byte address.
REQ-007 SHALL have port data_wdata  input  32  CPU write data.
REQ-008 SHALL have port data_wenable  input  4  per-byte write strobes, sampled at clk rising edge.
REQ-009 SHALL have port data_rdata  output  32  combinational read data for the addressed register.
REQ-010 SHALL have port tx  output  1  UART serial line, idle high.

Function
REQ-011 SHALL decode TXDATA at BASE_ADDR+0 and STATUS at BASE_ADDR+4; any other address is neither written nor read (data_rdata=0).
REQ-012 SHALL push data_wdata[7:0] into the FIFO on a rising edge with TXDATA addressed and data_wenable[0]=1; data_wenable[0]=0 means no push.
REQ-013 SHALL drop a push when the FIFO is full before that edge, even if a pop occurs on the same edge, and set sticky overrun.
REQ-014 STATUS read: bit0 busy (FSM not IDLE or FIFO non-empty), bit1 fifo_full, bit2 overrun, bits[15:8] FIFO level, other bits 0; TXDATA reads 0.
REQ-015 SHALL clear overrun on a STATUS write with data_wenable[0]=1 and data_wdata[2]=1; a same-edge overrun event wins.
REQ-016 FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START pops FIFO head when FIFO non-empty.
REQ-017 SHALL hold each bit exactly CLK_DIV cycles: START drives 0, DATA sends 8 bits LSB first, STOP drives 1, then IDLE.
REQ-018 SHALL go STOP->START directly (no idle cycle) when the FIFO is non-empty at the end of STOP.
REQ-019 Latency: a byte written at edge N into an empty FIFO with FSM IDLE drives tx low from edge N+1.
REQ-020 Bit counter 3 bits wraps 7->0 exactly at DATA exit; divider counts 0..CLK_DIV-1.

Reset
REQ-021 While rst is high at an edge: tx=1, FSM=IDLE, FIFO empty, overrun=0, counters 0; pushes that edge are discarded.
REQ-022 Reset mid-frame SHALL abort the frame; tx is 1 from the edge after rst is sampled.

Configuration
REQ-023 Macro CONSOLE_UART_PARITY_EN defined: PARITY state inserted between DATA and STOP, sending even parity (XOR of 8 data bits) for CLK_DIV cycles.
REQ-024 Macro undefined: PARITY state and logic absent; DATA->STOP directly; frame is 10 bit-times.

Structure
REQ-025 Package console_uart_pkg SHALL hold the FSM state enum, register offsets (TXDATA=0, STATUS=4) and STATUS bit indices.
REQ-026 FIFO SHALL be sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, level).

Verification
REQ-027 CLK_DIV=4: write 0x41 -> tx 0 for 4 cycles, then 1,0,0,0,0,0,1,0 at 4 cycles each, stop 1; frame 40 cycles, busy=0 after.
REQ-028 FIFO_DEPTH=4, idle: six TXDATA writes on consecutive edges -> 5 accepted, 6th dropped, STATUS bit2=1; five frames emitted back-to-back.
REQ-029 STATUS write 0x4 -> overrun reads 0; write with data_wenable=4'b0010 to TXDATA -> no push, level stays 0.
REQ-030 rst high mid-DATA of 0x55 with 2 bytes queued -> tx=1 next edge, STATUS reads 0, no further frames.
REQ-031 CONSOLE_UART_PARITY_EN, CLK_DIV=4: 0x41 -> parity bit 0; 0x07 -> parity bit 1; frame 44 cycles.
REQ-032 Read BASE_ADDR+8 -> data_rdata=0; write there -> FIFO level unchanged.
